// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
// Module  : accum_pkg
// Brief   : Shared state encoding and count-width helper for accum_nbit.
// Rev     : 1.0  initial release
// ============================================================================
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold 0..count inclusive, never less than one.
  function automatic int cnt_width(input int count);
    int w;
    w = $clog2(count + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/FA_nbit_Using_1bit_FA.sv
`default_nettype none
// ============================================================================
// Module  : FA_nbit_Using_1bit_FA (with leaf FA_1bit)
// Brief   : WIDTH-bit ripple-carry adder built from 1-bit full adders.
// Rev     : 1.0  initial release
// ============================================================================
module FA_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module FA_nbit_Using_1bit_FA #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin;
  assign cout       = w_carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    FA_1bit u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_carry[i]),
      .s    (sum[i]),
      .cout (w_carry[i+1])
    );
  end
endmodule
`default_nettype wire

// File: rtl/accum_nbit.sv
`default_nettype none
// ============================================================================
// Module  : accum_nbit
// Brief   : Sums COUNT accepted operands per block, presents sum/carry flag.
// Rev     : 1.0  initial release
// ============================================================================
module accum_nbit
  import accum_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int COUNT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_sum,
  output logic                          out_ovf,
  output logic [cnt_width(COUNT)-1:0]   out_cnt
);
  localparam int                 c_cnt_w = cnt_width(COUNT);
  localparam logic [c_cnt_w-1:0] c_count = c_cnt_w'(COUNT);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_acc, w_acc_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_xfer;

  FA_nbit_Using_1bit_FA #(.WIDTH(WIDTH)) u_add (
    .a    (r_acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Ready depends on state alone, so there is no in_valid -> in_ready path.
  assign in_ready  = (r_state != DONE);
  assign out_valid = (r_state == DONE);
  assign w_xfer    = in_valid & in_ready;
  assign w_cnt_inc = r_cnt + c_one;

  assign out_sum = r_acc;
  assign out_ovf = r_ovf;
  assign out_cnt = r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE, ACCUM: begin
        if (w_xfer) begin
          w_acc_nxt   = w_sum;
          w_ovf_nxt   = r_ovf | w_cout;
          w_cnt_nxt   = w_cnt_inc;
          w_state_nxt = (w_cnt_inc == c_count) ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_acc_nxt   = '0;
        w_ovf_nxt   = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_ovf   <= w_ovf_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accum_nbit.sv
`default_nettype none
// ============================================================================
// Module  : tb_accum_nbit
// Brief   : Scoreboard bench for accum_nbit (COUNT=4 main, COUNT=1 side unit).
// Rev     : 1.0  initial release
// ============================================================================
module tb_accum_nbit;
  import accum_pkg::*;

  localparam int W  = 4;
  localparam int C  = 4;
  localparam int CW = cnt_width(C);

  typedef struct {
    int sum;
    int ovf;
    int cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [W-1:0]  in_data, out_sum;
  logic [CW-1:0] out_cnt;

  logic          v1, rdy1, ov1, r1, ovf1;
  logic [W-1:0]  d1, sum1;
  logic [0:0]    cnt1;

  exp_t q[$];
  int   m_total, m_cnt;
  bit   m_pending;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  accum_nbit #(.WIDTH(W), .COUNT(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .out_cnt(out_cnt)
  );

  accum_nbit #(.WIDTH(W), .COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
    .in_data(d1), .out_valid(ov1), .out_ready(r1),
    .out_sum(sum1), .out_ovf(ovf1), .out_cnt(cnt1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a block is just the plain integer total of accepted operands.
  always @(posedge clk) begin
    if (!rst) begin
      if (m_pending) begin
        if (out_ready) begin
          m_pending = 1'b0;
          m_total   = 0;
          m_cnt     = 0;
        end
      end else if (in_valid) begin
        m_total += int'(in_data);
        m_cnt++;
        if (m_cnt == C) begin
          q.push_back('{sum: m_total % (1 << W), ovf: int'(m_total >= (1 << W)), cnt: C});
          m_pending = 1'b1;
        end
      end
    end
  end

  // Monitor: compares the presented result and handshake signals each cycle.
  always @(negedge clk) begin
    chk("out_valid", int'(out_valid), int'(q.size() != 0));
    chk("in_ready", int'(in_ready), int'(q.size() == 0));
    chk("out_cnt", int'(out_cnt), m_cnt);
    if (q.size() != 0) begin
      chk("out_sum", int'(out_sum), q[0].sum);
      chk("out_ovf", int'(out_ovf), q[0].ovf);
      if (out_ready) void'(q.pop_front());
    end
  end

  task automatic beat(input bit v, input int d, input bit ordy);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_data   = W'(d);
    out_ready = ordy;
  endtask

  task automatic block(input int a, input int b, input int c, input int d);
    beat(1, a, 0); beat(1, b, 0); beat(1, c, 0); beat(1, d, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) beat(0, 0, 1);
    chk("drain_timeout", q.size(), 0);
    beat(0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst       = 1'b1;
    m_total   = 0;
    m_cnt     = 0;
    m_pending = 1'b0;
    q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    v1 = 1'b0; d1 = '0; r1 = 1'b0;
    m_total = 0; m_cnt = 0; m_pending = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    chk("reset_sum", int'(out_sum), 0);
    chk("reset_ovf", int'(out_ovf), 0);
    chk("reset_ready", int'(in_ready), 1);

    block(1, 2, 3, 4);           drain();
    block(8, 8, 0, 0);           drain();
    block(1, 1, 1, 1);           drain();

    // Held result: in_valid pressure while the consumer stalls.
    block(2, 3, 5, 7);
    repeat (3) beat(1, 9, 0);
    beat(0, 0, 1);
    beat(0, 0, 0);

    for (int i = 0; i < 8; i++) beat(i % 2 == 0, 5, 0);
    drain();

    beat(1, 3, 1); beat(1, 3, 1);
    do_reset();
    block(4, 4, 4, 4);           drain();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 80) == 0) do_reset();
      else beat($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                $urandom_range(0, 2) == 0);
    end
    drain();

    // Single-operand blocks on the COUNT=1 unit.
    @(posedge clk); #2 v1 = 1'b1; d1 = 4'd7;
    @(negedge clk);
    chk("c1_valid_pre", int'(ov1), 0);
    chk("c1_ready_pre", int'(rdy1), 1);
    @(posedge clk); #2 v1 = 1'b0;
    @(negedge clk);
    chk("c1_valid", int'(ov1), 1);
    chk("c1_sum", int'(sum1), 7);
    chk("c1_cnt", int'(cnt1), 1);
    chk("c1_ovf", int'(ovf1), 0);
    chk("c1_ready", int'(rdy1), 0);
    @(posedge clk); #2 r1 = 1'b1; v1 = 1'b1; d1 = 4'd15;
    @(negedge clk);
    chk("c1_still_valid", int'(ov1), 1);
    @(posedge clk); #2 r1 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    chk("c1_idle", int'(ov1), 0);
    chk("c1_cnt_clr", int'(cnt1), 0);
    @(posedge clk); #2 v1 = 1'b1; d1 = 4'd15;
    @(posedge clk); #2 v1 = 1'b0;
    @(negedge clk);
    chk("c1_sum15", int'(sum1), 15);
    chk("c1_ovf15", int'(ovf1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/accum_nbit.md
ACCUM_NBIT -- requirements
Module: accum_nbit

Interface
REQ-001 Parameter WIDTH, default 4, operand and sum width in bits (WIDTH >= 1).
REQ-002 Parameter COUNT, default 4, operands summed per block (COUNT >= 1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand present on in_data.
REQ-006 in_ready  output  1  block can accept an operand this cycle.
REQ-007 in_data  input  WIDTH  unsigned operand.
REQ-008 out_valid  output  1  completed block sum presented.
REQ-009 out_ready  input  1  consumer takes result this cycle.
REQ-010 out_sum  output  WIDTH  block sum modulo 2^WIDTH.
REQ-011 out_ovf  output  1  sticky: any addition in the block produced carry-out.
REQ-012 out_cnt  output  clog2(COUNT+1) bits (min 1)  operands accepted in current block.

Function
REQ-013 The FSM SHALL have states IDLE, ACCUM, DONE.
REQ-014 An operand transfer SHALL occur only on a rising edge with in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM, 0 in DONE, derived from state only (no in_valid->in_ready path).
REQ-016 On each transfer the accumulator SHALL load acc + in_data (carry-in 0), out_ovf SHALL OR in the adder carry-out, and out_cnt SHALL increment.
REQ-017 IDLE: first transfer -> ACCUM (or directly DONE when COUNT=1); accumulator starts from 0.
REQ-018 ACCUM: transfer raising out_cnt to COUNT -> DONE; otherwise stay; no transfer -> stay, all state held.
REQ-019 out_valid SHALL be 1 exactly in DONE, first asserted the cycle after the COUNT-th transfer (latency 1 cycle).
REQ-020 In DONE out_sum, out_ovf, out_cnt SHALL stay stable until out_valid & out_ready.
REQ-021 On out_valid & out_ready: state -> IDLE, accumulator, out_ovf, out_cnt cleared to 0 on the same edge; no operand accepted that cycle.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 in_valid gaps mid-block SHALL not alter the result; only accepted operands count.
REQ-024 Wrap-around: sum bits beyond WIDTH SHALL be discarded; out_ovf records it and never clears within a block.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, accumulator 0, out_sum 0, out_ovf 0, out_cnt 0, out_valid 0, in_ready 1 (after deassertion).
REQ-026 Reset mid-block SHALL discard the partial block; the next accepted operand starts a fresh block.
REQ-027 While rst=1 no transfer SHALL be recorded regardless of in_valid.

Structure
REQ-028 State encodings (IDLE=0, ACCUM=1, DONE=2) and the out_cnt width function SHALL live in shared package accum_pkg.
REQ-029 The add SHALL use one instance of the team's WIDTH-bit ripple adder FA_nbit_Using_1bit_FA (Cin tied 0, Cout to overflow logic); no behavioural "+" on the datapath.
REQ-030 All registers SHALL sit in one always block with asynchronous rst; next-state/adder wiring combinational.

Verification
REQ-031 WIDTH=4, COUNT=4, in_data 1,2,3,4 back-to-back -> out_valid one cycle after 4th beat, out_sum=10, out_ovf=0, out_cnt=4.
REQ-032 in_data 8,8,0,0 -> out_sum=0, out_ovf=1; next block 1,1,1,1 -> out_sum=4, out_ovf=0.
REQ-033 Block done, out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged, no operand consumed; out_ready=1 -> IDLE next cycle.
REQ-034 in_valid toggling 1,0,1,0,... with data 5,5,5,5 -> out_sum=4 (20 mod 16), out_ovf=1, only 4 transfers counted.
REQ-035 rst pulsed after 2 accepted operands (3,3) then 4,4,4,4 -> out_sum=0, out_ovf=1 (16 wraps), partial 6 absent.
REQ-036 COUNT=1, in_data 7 -> out_valid next cycle, out_sum=7, out_cnt=1.
